data_io_sched: RTL and testbench

- Schedules host-side read/write requests onto the data-memory IO port.
- Requests are queued in an in-order FIFO and issued only while the micro is not busy, so host traffic never collides with ALU write-back.
- Sits between the host interface and the data-execute cluster: drives its wen_io/waddr_io/wdata_io/ren_io/raddr_io inputs and consumes rdata_io.
- Returns read data to the host through a valid/ready response channel.

---
 rtl/data_io_sched.sv | 205 ++++++++++++++++++++
 tb/tb_data_io_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_io_sched.sv
// data_io_sched: queues host read/write requests and issues them onto the
// data-memory IO port only while the micro is idle (busy low). Reads return
// through a valid/ready response channel, with one read outstanding at a time.
// Optional feature macro: IO_STALL_CNT_EN enables the busy-stall counter on
// stall_cnt; without it stall_cnt is tied to zero.
module data_io_sched #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 256,
    parameter int QDEPTH = 4,
    parameter int RD_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    input  logic                        busy,
    output logic                        wen_io,
    output logic [ADDR_W-1:0]           waddr_io,
    output logic [DATA_W-1:0]           wdata_io,
    output logic                        ren_io,
    output logic [ADDR_W-1:0]           raddr_io,
    input  logic [DATA_W-1:0]           rdata_io,
    output logic [$clog2(QDEPTH):0]     q_level,
    output logic [31:0]                 stall_cnt
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + DATA_W;
    localparam logic [1:0]       LAT_LOAD = 2'(RD_LAT);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RSP     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ENT_W-1:0]  fifo_mem [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic [LVL_W-1:0]  count_next;
    logic              ready_q;
    logic              push;
    logic              pop;

    logic              head_we;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    logic              issue_wr;
    logic              issue_rd;
    logic              capture;
    logic              rsp_done;
    logic [1:0]        lat_cnt;
    logic [1:0]        lat_next;

    assign push      = req_valid && ready_q;
    assign req_ready = ready_q;
    assign q_level   = count;

    assign {head_we, head_addr, head_wdata} = fifo_mem[rd_ptr];

    // Occupancy after this cycle's push/pop, used for the count and for the registered ready.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + LVL_W'(1);
            2'b01:   count_next = count - LVL_W'(1);
            default: count_next = count;
        endcase
    end

    // Request storage; entries are only meaningful between the read and write pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_we, req_addr, req_wdata};
        end
    end

    // FIFO pointers, occupancy and the conservative registered ready (!full).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_next;
            ready_q <= (count_next != LVL_FULL);
        end
    end

    // Next-state logic: pop/issue only in IDLE with busy low, then wait out the read latency.
    always_comb begin
        state_next = state;
        lat_next   = lat_cnt;
        pop        = 1'b0;
        issue_wr   = 1'b0;
        issue_rd   = 1'b0;
        capture    = 1'b0;
        rsp_done   = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && !busy) begin
                    pop = 1'b1;
                    if (head_we) begin
                        issue_wr = 1'b1;
                    end else begin
                        issue_rd   = 1'b1;
                        lat_next   = LAT_LOAD;
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    capture    = 1'b1;
                    state_next = RSP;
                end else begin
                    lat_next = lat_cnt - 2'd1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and read-latency counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_next;
        end
    end

    // Registered memory-side strobes; address/data are zero whenever nothing is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen_io   <= 1'b0;
            waddr_io <= '0;
            wdata_io <= '0;
            ren_io   <= 1'b0;
            raddr_io <= '0;
        end else begin
            wen_io   <= issue_wr;
            waddr_io <= issue_wr ? head_addr  : '0;
            wdata_io <= issue_wr ? head_wdata : '0;
            ren_io   <= issue_rd;
            raddr_io <= issue_rd ? head_addr  : '0;
        end
    end

    // Response channel: capture read data once latency expires, hold until the host takes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_io;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef IO_STALL_CNT_EN
    // Count cycles where queued work is blocked only by busy; saturates, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((count != '0) && (state == IDLE) && busy && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_data_io_sched.sv
// Testbench for data_io_sched: table-driven per-cycle vectors for the basic
// write/read and busy-gating flows, plus hand sequences for response
// backpressure, busy during a read, reset mid-read and the stall counter.
module tb_data_io_sched;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 256;
    localparam int QDEPTH = 4;
    localparam int RD_LAT = 1;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [ADDR_W-1:0]  req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_rdata;
    logic               busy;
    logic               wen_io;
    logic [ADDR_W-1:0]  waddr_io;
    logic [DATA_W-1:0]  wdata_io;
    logic               ren_io;
    logic [ADDR_W-1:0]  raddr_io;
    logic [DATA_W-1:0]  rdata_io;
    logic [2:0]         q_level;
    logic [31:0]        stall_cnt;

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;

    logic [DATA_W-1:0] mem_model [256];

    localparam logic [DATA_W-1:0] PAT_A5   = {32{8'hA5}};
    localparam logic [DATA_W-1:0] PAT_BEEF = {16{16'hBEEF}};
    localparam logic [DATA_W-1:0] PAT_X    = {8{32'h1111_0010}};
    localparam logic [DATA_W-1:0] PAT_Y    = {8{32'h2222_0011}};
    localparam logic [DATA_W-1:0] PAT_Z    = {8{32'h3333_0020}};

`ifdef IO_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd10;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    typedef struct {
        logic              valid;
        logic              we;
        logic [7:0]        addr;
        logic [DATA_W-1:0] wdata;
        logic              busy;
        logic              rsp_ready;
        logic              e_ready;
        logic              e_wen;
        logic [7:0]        e_waddr;
        logic [DATA_W-1:0] e_wdata;
        logic              e_ren;
        logic [7:0]        e_raddr;
        logic              e_rsp_valid;
        logic [DATA_W-1:0] e_rdata;
        logic [2:0]        e_level;
    } vec_t;

    vec_t vecs [16];

    data_io_sched #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .QDEPTH(QDEPTH),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .busy(busy),
        .wen_io(wen_io),
        .waddr_io(waddr_io),
        .wdata_io(wdata_io),
        .ren_io(ren_io),
        .raddr_io(raddr_io),
        .rdata_io(rdata_io),
        .q_level(q_level),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-memory model with a one-cycle registered read port.
    always @(posedge clk) begin
        if (wen_io) begin
            mem_model[waddr_io] <= wdata_io;
        end
        if (ren_io) begin
            rdata_io <= mem_model[raddr_io];
        end
    end

    // Watch for a write and read strobe in the same cycle.
    always @(negedge clk) begin
        if (rst_n && wen_io && ren_io) begin
            overlap_cnt = overlap_cnt + 1;
        end
    end

    function automatic logic [DATA_W-1:0] busyPat(input logic [7:0] a);
        logic [7:0] b;
        b = 8'hD0 | a;
        return {32{b}};
    endfunction

    function automatic vec_t mk(
        input logic valid, input logic we, input logic [7:0] addr, input logic [DATA_W-1:0] wdata,
        input logic bsy, input logic rrdy,
        input logic e_ready, input logic e_wen, input logic [7:0] e_waddr, input logic [DATA_W-1:0] e_wdata,
        input logic e_ren, input logic [7:0] e_raddr, input logic e_rv, input logic [DATA_W-1:0] e_rdata,
        input logic [2:0] e_level);
        vec_t v;
        v.valid = valid; v.we = we; v.addr = addr; v.wdata = wdata;
        v.busy = bsy; v.rsp_ready = rrdy;
        v.e_ready = e_ready; v.e_wen = e_wen; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
        v.e_ren = e_ren; v.e_raddr = e_raddr; v.e_rsp_valid = e_rv; v.e_rdata = e_rdata;
        v.e_level = e_level;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic we, input logic [7:0] addr, input logic [DATA_W-1:0] wdata);
        req_valid = valid;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        drive(v.valid, v.we, v.addr, v.wdata);
        busy      = v.busy;
        rsp_ready = v.rsp_ready;
        step();
        checkOutput($sformatf("v%0d_req_ready", idx), DATA_W'(req_ready), DATA_W'(v.e_ready));
        checkOutput($sformatf("v%0d_wen_io", idx), DATA_W'(wen_io), DATA_W'(v.e_wen));
        checkOutput($sformatf("v%0d_ren_io", idx), DATA_W'(ren_io), DATA_W'(v.e_ren));
        checkOutput($sformatf("v%0d_rsp_valid", idx), DATA_W'(rsp_valid), DATA_W'(v.e_rsp_valid));
        checkOutput($sformatf("v%0d_q_level", idx), DATA_W'(q_level), DATA_W'(v.e_level));
        if (v.e_wen) begin
            checkOutput($sformatf("v%0d_waddr_io", idx), DATA_W'(waddr_io), DATA_W'(v.e_waddr));
            checkOutput($sformatf("v%0d_wdata_io", idx), wdata_io, v.e_wdata);
        end
        if (v.e_ren) begin
            checkOutput($sformatf("v%0d_raddr_io", idx), DATA_W'(raddr_io), DATA_W'(v.e_raddr));
        end
        if (v.e_rsp_valid) begin
            checkOutput($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.e_rdata);
        end
    endtask

    initial begin
        // Write 05 then read 05, busy low; wen two cycles after the accept cycle.
        vecs[0]  = mk(1, 1, 8'h05, PAT_A5, 0, 1,  1, 0, 8'h00, '0,     0, 8'h00, 0, '0,     3'd1);
        vecs[1]  = mk(1, 0, 8'h05, '0,     0, 1,  1, 1, 8'h05, PAT_A5, 0, 8'h00, 0, '0,     3'd1);
        vecs[2]  = mk(0, 0, 8'h00, '0,     0, 1,  1, 0, 8'h00, '0,     1, 8'h05, 0, '0,     3'd0);
        vecs[3]  = mk(0, 0, 8'h00, '0,     0, 1,  1, 0, 8'h00, '0,     0, 8'h00, 0, '0,     3'd0);
        vecs[4]  = mk(0, 0, 8'h00, '0,     0, 1,  1, 0, 8'h00, '0,     0, 8'h00, 1, PAT_A5, 3'd0);
        vecs[5]  = mk(0, 0, 8'h00, '0,     0, 1,  1, 0, 8'h00, '0,     0, 8'h00, 0, '0,     3'd0);
        // Busy gating: fill to four, then drain one write per cycle in order.
        vecs[6]  = mk(1, 1, 8'h00, busyPat(8'h00), 1, 1,  1, 0, 8'h00, '0, 0, 8'h00, 0, '0, 3'd1);
        vecs[7]  = mk(1, 1, 8'h01, busyPat(8'h01), 1, 1,  1, 0, 8'h00, '0, 0, 8'h00, 0, '0, 3'd2);
        vecs[8]  = mk(1, 1, 8'h02, busyPat(8'h02), 1, 1,  1, 0, 8'h00, '0, 0, 8'h00, 0, '0, 3'd3);
        vecs[9]  = mk(1, 1, 8'h03, busyPat(8'h03), 1, 1,  0, 0, 8'h00, '0, 0, 8'h00, 0, '0, 3'd4);
        vecs[10] = mk(1, 1, 8'h04, busyPat(8'h04), 1, 1,  0, 0, 8'h00, '0, 0, 8'h00, 0, '0, 3'd4);
        vecs[11] = mk(0, 0, 8'h00, '0, 0, 1,  1, 1, 8'h00, busyPat(8'h00), 0, 8'h00, 0, '0, 3'd3);
        vecs[12] = mk(0, 0, 8'h00, '0, 0, 1,  1, 1, 8'h01, busyPat(8'h01), 0, 8'h00, 0, '0, 3'd2);
        vecs[13] = mk(0, 0, 8'h00, '0, 0, 1,  1, 1, 8'h02, busyPat(8'h02), 0, 8'h00, 0, '0, 3'd1);
        vecs[14] = mk(0, 0, 8'h00, '0, 0, 1,  1, 1, 8'h03, busyPat(8'h03), 0, 8'h00, 0, '0, 3'd0);
        vecs[15] = mk(0, 0, 8'h00, '0, 0, 1,  1, 0, 8'h00, '0, 0, 8'h00, 0, '0, 3'd0);

        rst_n     = 1'b0;
        busy      = 1'b0;
        rsp_ready = 1'b0;
        drive(0, 0, 8'h00, '0);
        repeat (3) step();
        checkOutput("rst_req_ready", DATA_W'(req_ready), DATA_W'(1));
        checkOutput("rst_q_level", DATA_W'(q_level), DATA_W'(0));
        checkOutput("rst_wen_ren", DATA_W'({wen_io, ren_io}), DATA_W'(0));
        checkOutput("rst_rsp_valid", DATA_W'(rsp_valid), DATA_W'(0));
        checkOutput("rst_stall_cnt", DATA_W'(stall_cnt), DATA_W'(0));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Response backpressure: held response blocks two queued writes.
        busy = 1'b0;
        rsp_ready = 1'b0;
        drive(1, 1, 8'hFF, PAT_BEEF); step();
        drive(1, 0, 8'hFF, '0);       step();
        drive(1, 1, 8'h10, PAT_X);    step();
        checkOutput("bp_ren_io", DATA_W'(ren_io), DATA_W'(1));
        drive(1, 1, 8'h11, PAT_Y);    step();
        drive(0, 0, 8'h00, '0);       step();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp_hold%0d_rsp_valid", i), DATA_W'(rsp_valid), DATA_W'(1));
            checkOutput($sformatf("bp_hold%0d_rsp_rdata", i), rsp_rdata, PAT_BEEF);
            checkOutput($sformatf("bp_hold%0d_no_issue", i), DATA_W'({wen_io, ren_io}), DATA_W'(0));
            step();
        end
        checkOutput("bp_q_level", DATA_W'(q_level), DATA_W'(2));
        rsp_ready = 1'b1;
        step();
        checkOutput("bp_handshake_rsp_valid", DATA_W'(rsp_valid), DATA_W'(0));
        step();
        checkOutput("bp_w0_wen", DATA_W'(wen_io), DATA_W'(1));
        checkOutput("bp_w0_waddr", DATA_W'(waddr_io), DATA_W'(8'h10));
        checkOutput("bp_w0_wdata", wdata_io, PAT_X);
        step();
        checkOutput("bp_w1_wen", DATA_W'(wen_io), DATA_W'(1));
        checkOutput("bp_w1_waddr", DATA_W'(waddr_io), DATA_W'(8'h11));
        checkOutput("bp_w1_wdata", wdata_io, PAT_Y);
        step();

        // Busy rises the cycle after ren_io; the read still completes, the next write waits.
        drive(1, 0, 8'h05, '0);  step();
        drive(1, 1, 8'h20, PAT_Z); step();
        checkOutput("bm_ren_io", DATA_W'(ren_io), DATA_W'(1));
        checkOutput("bm_raddr_io", DATA_W'(raddr_io), DATA_W'(8'h05));
        drive(0, 0, 8'h00, '0);
        busy = 1'b1;
        step();
        checkOutput("bm_wait_rsp_valid", DATA_W'(rsp_valid), DATA_W'(0));
        step();
        checkOutput("bm_rsp_valid", DATA_W'(rsp_valid), DATA_W'(1));
        checkOutput("bm_rsp_rdata", rsp_rdata, PAT_A5);
        step();
        checkOutput("bm_done_rsp_valid", DATA_W'(rsp_valid), DATA_W'(0));
        repeat (2) step();
        checkOutput("bm_held_wen", DATA_W'(wen_io), DATA_W'(0));
        checkOutput("bm_held_q_level", DATA_W'(q_level), DATA_W'(1));
        busy = 1'b0;
        step();
        checkOutput("bm_release_wen", DATA_W'(wen_io), DATA_W'(1));
        checkOutput("bm_release_waddr", DATA_W'(waddr_io), DATA_W'(8'h20));
        step();

        // Reset while a read is in RD_WAIT with three writes queued.
        busy = 1'b1;
        drive(1, 0, 8'h05, '0);    step();
        drive(1, 1, 8'h30, PAT_X); step();
        drive(1, 1, 8'h31, PAT_X); step();
        drive(1, 1, 8'h32, PAT_X); step();
        drive(0, 0, 8'h00, '0);
        busy = 1'b0;
        step();
        checkOutput("rm_ren_io", DATA_W'(ren_io), DATA_W'(1));
        checkOutput("rm_q_level", DATA_W'(q_level), DATA_W'(3));
        rst_n = 1'b0;
        step();
        checkOutput("rm_q_level_cleared", DATA_W'(q_level), DATA_W'(0));
        checkOutput("rm_rsp_valid", DATA_W'(rsp_valid), DATA_W'(0));
        checkOutput("rm_wen_ren", DATA_W'({wen_io, ren_io}), DATA_W'(0));
        checkOutput("rm_req_ready", DATA_W'(req_ready), DATA_W'(1));
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput($sformatf("rm_after%0d_quiet", i), DATA_W'({rsp_valid, wen_io, ren_io}), DATA_W'(0));
        end

        // Stall counter: one queued entry held by busy for ten cycles.
        busy = 1'b1;
        drive(1, 1, 8'h40, PAT_Z); step();
        drive(0, 0, 8'h00, '0);
        repeat (10) step();
        checkOutput("stall_cnt_10", DATA_W'(stall_cnt), DATA_W'(EXP_STALL));
        busy = 1'b0;
        step();
        checkOutput("stall_drain_wen", DATA_W'(wen_io), DATA_W'(1));
        checkOutput("stall_drain_waddr", DATA_W'(waddr_io), DATA_W'(8'h40));
        checkOutput("stall_cnt_hold", DATA_W'(stall_cnt), DATA_W'(EXP_STALL));
        step();

        checkOutput("no_wen_ren_overlap", DATA_W'(overlap_cnt), DATA_W'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
